// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// read-only fetch port (if_*) and the read/write load/store port (ls_*).
module mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic   last_ls;
  logic   grant_ls;
  logic   pick_ls;

  // LS wins when it is alone, or when both ask and IF was served last
  always_comb begin
    pick_ls = ls_req && (!if_req || !last_ls);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_ls  <= 1'b1;
      grant_ls <= 1'b0;
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      if_rdata <= '0;
      ls_rdata <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      ls_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            grant_ls <= pick_ls;
            last_ls  <= pick_ls;
            mem_addr <= pick_ls ? ls_addr : if_addr;
            if (pick_ls) begin
              mem_data <= ls_wdata;
            end
            mem_we   <= pick_ls && ls_we;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          // mem_q carries the word captured at the end of ACCESS
          if (grant_ls) begin
            ls_ack   <= 1'b1;
            ls_rdata <= mem_q;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= mem_q;
          end
          state <= IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
